// File: rtl/bfp_block_norm_if.sv
// Stream bus for the block floating-point normaliser: sample input side and
// normalised sample output side with the block exponent.
interface bfp_block_norm_if #(
  parameter int WIDTH     = 23,
  parameter int BLOCK_LEN = 16
);
  localparam int IDX_W = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [IDX_W-1:0] out_shift;
  logic             out_last;

  // Producer/consumer side (testbench or surrounding logic)
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_shift, out_last
  );

  // Normaliser side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_shift, out_last
  );
endinterface

// File: rtl/bfp_block_norm.sv
// Block floating-point normaliser: buffers BLOCK_LEN samples, finds the largest
// magnitude index, then replays the block left-shifted by a common exponent.
module bfp_block_norm #(
  parameter int WIDTH     = 23,
  parameter int BLOCK_LEN = 16
) (
  input logic            clk,
  input logic            reset,
  bfp_block_norm_if.slave bus
);
  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(BLOCK_LEN);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(BLOCK_LEN - 1);
  localparam logic [IDX_W-1:0] MAX_SH = IDX_W'(WIDTH - 2);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [IDX_W-1:0] m_q, m_d, shift_q, shift_d;
  logic             rdy_en_q;
  logic [WIDTH-1:0] buf_q [BLOCK_LEN];

  logic             in_fire;
  logic [IDX_W-1:0] in_idx, m_new;
  logic             in_ready, out_valid, out_last;
  logic [WIDTH-1:0] out_data;
  logic [IDX_W-1:0] out_shift;

  // Magnitude index: folding negative values onto their one's complement makes
  // "highest 0" of a negative sample the same search as "highest 1".
  function automatic logic [IDX_W-1:0] idx_f(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] y;
    idx_f = '0;
    y = x ^ {WIDTH{x[WIDTH-1]}};
    for (int i = 0; i < WIDTH - 1; i++)
      if (y[i]) idx_f = IDX_W'(i);
  endfunction

  assign in_idx = idx_f(bus.in_data);
  assign m_new  = (in_idx > m_q) ? in_idx : m_q;

  // Next-state and output decode; outputs default to zero outside DRAIN
  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    m_d       = m_q;
    shift_d   = shift_q;
    in_ready  = 1'b0;
    in_fire   = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_shift = '0;
    out_data  = '0;
    case (state_q)
      FILL: begin
        // rdy_en_q keeps in_ready low through reset and until the first edge after
        in_ready = rdy_en_q;
        in_fire  = bus.in_valid && rdy_en_q;
        if (in_fire) begin
          if (wr_cnt_q == LAST) begin
            wr_cnt_d = '0;
            m_d      = '0;
            shift_d  = MAX_SH - m_new;
            state_d  = DRAIN;
          end else begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
            m_d      = m_new;
          end
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_shift = shift_q;
        out_last  = (rd_cnt_q == LAST);
        // Shift never overflows: shift was chosen from the block's largest index
        out_data  = buf_q[rd_cnt_q] << shift_q;
        if (bus.out_ready) begin
          if (out_last) begin
            rd_cnt_d = '0;
            state_d  = FILL;
          end else begin
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;
  assign bus.out_shift = out_shift;
  assign bus.out_data  = out_data;

  // Control state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FILL;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      m_q      <= '0;
      shift_q  <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      m_q      <= m_d;
      shift_q  <= shift_d;
      rdy_en_q <= 1'b1;
    end
  end

  // Sample buffer; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (in_fire) buf_q[wr_cnt_q] <= bus.in_data;
  end
endmodule

// File: doc/bfp_block_norm.md
BFP_BLOCK_NORM -- requirements
Module: bfp_block_norm

Interface
REQ-001 SHALL have parameter WIDTH, default 23, sample width in bits, signed two's complement; legal range WIDTH >= 4.
REQ-002 SHALL have parameter BLOCK_LEN, default 16, samples per block; legal range BLOCK_LEN >= 2.
REQ-003 SHALL have derived parameter IDX_W = $clog2(WIDTH), the width of the index and shift fields.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  block accepts a sample this cycle.
REQ-008 in_data  input  WIDTH  signed input sample.
REQ-009 out_valid  output  1  out_data, out_shift and out_last are valid.
REQ-010 out_ready  input  1  downstream accepts the output this cycle.
REQ-011 out_data  output  WIDTH  signed normalised sample.
REQ-012 out_shift  output  IDX_W  common left-shift applied to the current block (block exponent).
REQ-013 out_last  output  1  marks the final sample of a block.

Function
REQ-014 SHALL compute a per-sample magnitude index idx(x) as follows:
- x == 0 or x == -1: idx = 0.
- x >= 0: idx = position of the highest 1 in bits [WIDTH-2:0].
- x < 0: idx = position of the highest 0 in bits [WIDTH-2:0].
REQ-015 SHALL implement a two-state FSM, FILL and DRAIN; the reset state is FILL.
REQ-016 In FILL, SHALL drive in_ready=1 and out_valid=0.
REQ-017 In FILL, a transfer occurs when in_valid && in_ready; on each transfer SHALL:
- write in_data to buffer[wr_cnt];
- increment wr_cnt;
- update running max M = max(M, idx(in_data)).
REQ-018 On the transfer with wr_cnt == BLOCK_LEN-1, SHALL:
- register shift = (WIDTH-2) - max(M, idx(in_data));
- clear wr_cnt and M;
- enter DRAIN on the next cycle.
REQ-019 In DRAIN, SHALL drive in_ready=0 and out_valid=1 from the first DRAIN cycle, i.e. one cycle after the last input transfer.
REQ-020 In DRAIN, SHALL drive the outputs as follows:
- out_data = buffer[rd_cnt] arithmetically shifted left by shift;
- out_shift = shift;
- out_last = (rd_cnt == BLOCK_LEN-1).
REQ-021 The left shift SHALL never overflow (guaranteed by the choice of shift); no saturation logic is required.
REQ-022 A DRAIN handshake occurs when out_valid && out_ready; on each handshake SHALL increment rd_cnt.
REQ-023 On the handshake with out_last=1, SHALL clear rd_cnt and return to FILL on the next cycle.
REQ-024 While out_ready=0 in DRAIN, SHALL hold out_data, out_shift, out_last and rd_cnt stable.
REQ-025 SHALL ignore in_valid while in DRAIN; no sample is written or dropped silently, since in_ready=0.
REQ-026 SHALL treat an all-zero or all-(-1) block as M=0, giving shift = WIDTH-2.
REQ-027 A block containing -2^(WIDTH-1) or 2^(WIDTH-1)-1 SHALL produce shift=0 (pass-through).
REQ-028 Throughput SHALL be one block per 2*BLOCK_LEN cycles when in_valid and out_ready are both held at 1.

Reset
REQ-029 On reset assertion, SHALL immediately force the following, regardless of state:
- state=FILL;
- wr_cnt=0, rd_cnt=0, M=0, shift=0;
- out_valid=0, out_last=0, out_data=0, out_shift=0.
REQ-030 Buffer contents need no reset; a partial block in progress at reset SHALL be discarded.
REQ-031 While reset is asserted, SHALL hold in_ready=0; it SHALL rise to 1 on the first clock edge after reset deasserts.

Verification (WIDTH=8, BLOCK_LEN=4)
REQ-032 Input {5,-3,1,0} -> idx {2,1,0,0}; out_shift=4; out_data {80,-48,16,0}; out_last=1 only on the 4th output.
REQ-033 Input {0,0,0,0} -> out_shift=6; out_data {0,0,0,0}. Input {-1,-1,-1,-1} -> out_shift=6; out_data {-64,-64,-64,-64}.
REQ-034 Input {-128,1,2,3} -> out_shift=0; out_data {-128,1,2,3}.
REQ-035 out_ready held at 0 for 3 cycles mid-DRAIN:
- out_data and out_shift are stable and in_ready=0 throughout;
- the sequence resumes without loss or duplication.
REQ-036 Reset asserted after 2 FILL transfers:
- outputs read zero and in_ready=0 immediately;
- after release, block {5,-3,1,0} still yields exactly REQ-032.
REQ-037 With in_valid=1 continuously, 4 input transfers are followed by 4 output handshakes, and in_ready returns to 1 one cycle after the last output handshake.
